// File: rtl/rand_pick_pkg.sv
// Shared types and constants for the rejection-sampling random value picker.
package rand_pick_pkg;

   localparam int VAL_W         = 4;
   localparam int MAX_RETRY_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      STEP,
      SAMPLE,
      OUT
   } state_t;

endpackage

// File: rtl/rand_pick.sv
// Steps an external LFSR and keeps the first nonzero sample <= bound; fallback to bound after MAX_RETRY samples.
// Latency 1+2*attempts cycles from request edge to o_valid; o_valid and the result hold until i_ready.
module rand_pick
   import rand_pick_pkg::*;
#(
   parameter int MAX_RETRY = MAX_RETRY_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_req,
   input  logic [VAL_W-1:0] i_bound,
   input  logic [VAL_W-1:0] i_lfsr,
   output logic             o_lfsr_step,
   output logic [VAL_W-1:0] o_value,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_fallback,
   output logic [VAL_W-1:0] o_attempts,
   output logic             o_busy
);

   localparam logic [VAL_W-1:0] MAX_A = VAL_W'(MAX_RETRY);

   state_t           state;
   state_t           state_n;
   logic [VAL_W-1:0] bound_r;
   logic [VAL_W-1:0] attempts_r;
   logic [VAL_W-1:0] value_r;
   logic             fallback_r;
   logic             step_r;
   logic             accept;

   // Zero is the LFSR lock-up value and is never a legal pick.
   assign accept = (i_lfsr != '0) && (i_lfsr <= bound_r);

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (i_req) state_n = STEP;
         STEP:    state_n = SAMPLE;
         SAMPLE:  if (accept || (attempts_r >= MAX_A)) state_n = OUT;
                  else state_n = STEP;
         OUT:     if (i_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         step_r     <= 1'b0;
         bound_r    <= '0;
         attempts_r <= '0;
         value_r    <= '0;
         fallback_r <= 1'b0;
      end else begin
         state  <= state_n;
         // Step is registered off the next state so it is high exactly during STEP.
         step_r <= (state_n == STEP);
         if ((state == IDLE) && i_req) begin
            bound_r    <= i_bound;
            attempts_r <= '0;
         end
         if ((state == STEP) && (attempts_r < MAX_A))
            attempts_r <= attempts_r + VAL_W'(1);
         if ((state == SAMPLE) && (state_n == OUT)) begin
            value_r    <= accept ? i_lfsr : bound_r;
            fallback_r <= ~accept;
         end
      end
   end

   assign o_lfsr_step = step_r;
   assign o_value     = value_r;
   assign o_valid     = (state == OUT);
   assign o_fallback  = fallback_r;
   assign o_attempts  = attempts_r;
   assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_rand_pick.sv
// Bench for rand_pick: drives a seed-3 LFSR from the step pulse and checks each pick against a table-driven model.
module tb_rand_pick;

   localparam int MR = rand_pick_pkg::MAX_RETRY_DEF;

   logic       i_clk   = 1'b0;
   logic       i_rst_n = 1'b1;
   logic       i_req   = 1'b0;
   logic       i_ready = 1'b0;
   logic [3:0] i_bound = '0;
   logic [3:0] lfsr;
   logic       o_lfsr_step;
   logic       o_valid;
   logic       o_fallback;
   logic       o_busy;
   logic [3:0] o_value;
   logic [3:0] o_attempts;

   int   n_chk    = 0;
   int   n_pass   = 0;
   int   dbl_step = 0;
   logic prev_step = 1'b0;
   int   lpos     = 0;
   int   seq[15]  = '{9, 4, 2, 1, 8, 12, 14, 15, 7, 11, 5, 10, 13, 6, 3};

   always #5 i_clk = ~i_clk;

   // 4-bit LFSR generator, seed 3, enabled by the DUT step pulse.
   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)         lfsr <= 4'd3;
      else if (o_lfsr_step) lfsr <= {lfsr[3] ^ lfsr[0], lfsr[3:1]};
   end

   always @(negedge i_clk) begin
      if (o_lfsr_step && prev_step) dbl_step <= dbl_step + 1;
      prev_step <= o_lfsr_step;
   end

   rand_pick #(.MAX_RETRY(MR)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_req       (i_req),
      .i_bound     (i_bound),
      .i_lfsr      (lfsr),
      .o_lfsr_step (o_lfsr_step),
      .o_value     (o_value),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_fallback  (o_fallback),
      .o_attempts  (o_attempts),
      .o_busy      (o_busy)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // Draw samples from the known sequence until one lies in 1..b or the retry budget runs out.
   task automatic model(input int b, output int val, output int fb, output int n);
      int s;
      bit done;
      done = 0; val = b; fb = 1; n = 0;
      for (int i = 0; i < MR; i++) begin
         if (!done) begin
            s = seq[lpos % 15];
            lpos++;
            n++;
            if (s != 0 && s <= b) begin
               val  = s;
               fb   = 0;
               done = 1;
            end
         end
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_step"},     int'(o_lfsr_step), 0);
      chk({tag, "_valid"},    int'(o_valid),     0);
      chk({tag, "_value"},    int'(o_value),     0);
      chk({tag, "_fallback"}, int'(o_fallback),  0);
      chk({tag, "_attempts"}, int'(o_attempts),  0);
      chk({tag, "_busy"},     int'(o_busy),      0);
   endtask

   task automatic pulse_reset();
      @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      lpos = 0;
   endtask

   task automatic do_req(input int b, input int d);
      int ev, efb, en, cyc, steps;
      bit seen;
      @(negedge i_clk);
      chk("idle_busy", int'(o_busy), 0);
      i_req   = 1'b1;
      i_bound = 4'(b);
      @(posedge i_clk);
      #1 i_req = 1'b0;
      model(b, ev, efb, en);
      cyc = 0; steps = 0; seen = 0;
      while (!seen && cyc < 40) begin
         @(negedge i_clk);
         cyc++;
         if (o_lfsr_step) steps++;
         if (o_valid) begin
            seen  = 1;
            i_req = 1'b0;
         end else begin
            i_req = 1'($urandom_range(0, 1));
         end
      end
      chk("latency",  cyc, 1 + 2 * en);
      chk("steps",    steps, en);
      chk("value",    int'(o_value), ev);
      chk("fallback", int'(o_fallback), efb);
      chk("attempts", int'(o_attempts), en);
      chk("busy_out", int'(o_busy), 1);
      for (int k = 0; k < d; k++) begin
         @(negedge i_clk);
         chk("hold_valid",    int'(o_valid), 1);
         chk("hold_value",    int'(o_value), ev);
         chk("hold_attempts", int'(o_attempts), en);
         chk("hold_step",     int'(o_lfsr_step), 0);
         chk("hold_busy",     int'(o_busy), 1);
      end
      i_ready = 1'b1;
      @(posedge i_clk);
      #1 i_ready = 1'b0;
      @(negedge i_clk);
      chk("post_valid", int'(o_valid), 0);
      chk("post_busy",  int'(o_busy), 0);
   endtask

   initial begin
      int ev, efb, en, ndel;

      #1 i_rst_n = 1'b0;
      #1 chk_reset_outputs("rst");
      @(negedge i_clk);
      i_rst_n = 1'b1;

      do_req(15, 0);   // first-try accept: 9
      do_req(3, 0);    // 4 rejected, 2 accepted
      do_req(0, 0);    // never accepts: fallback 0 after MR samples
      do_req(15, 5);   // consumer stalls in OUT

      // Abort a retrying request while it is sampling.
      @(negedge i_clk);
      i_req   = 1'b1;
      i_bound = 4'd0;
      @(posedge i_clk);
      #1 i_req = 1'b0;
      repeat (4) @(negedge i_clk);
      chk("pre_rst_attempts", int'(o_attempts), 2);
      chk("pre_rst_busy",     int'(o_busy), 1);
      #2 i_rst_n = 1'b0;
      #1 chk_reset_outputs("abort");
      @(negedge i_clk);
      i_rst_n = 1'b1;
      lpos = 0;
      do_req(15, 0);

      // Request held high: IDLE is revisited right after each handshake.
      pulse_reset();
      @(negedge i_clk);
      i_req   = 1'b1;
      i_bound = 4'd15;
      i_ready = 1'b1;
      @(posedge i_clk);
      ndel = 0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge i_clk);
         if (o_valid) begin
            model(15, ev, efb, en);
            chk("b2b_value", int'(o_value), ev);
            chk("b2b_cycle", k, 3 + 4 * ndel);
            ndel++;
         end
      end
      i_req   = 1'b0;
      i_ready = 1'b0;
      chk("b2b_count", ndel, 4);

      for (int r = 0; r < 30; r++)
         do_req(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));

      @(negedge i_clk);
      chk("step_gap", dbl_step, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
